// File: rtl/ppu_pkg.sv
// Shared PPU definitions: sprite-search state encoding, OAM layout constants,
// slot record format and the sprite/line intersection arithmetic.
package ppu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN_Y,
        S_SCAN_X,
        S_FINISH
    } scan_state_t;

    localparam int OAM_ENTRY_BYTES = 4;
    localparam int OAM_Y_OFS       = 0;
    localparam int OAM_X_OFS       = 1;

    localparam int SPRITE_Y_BIAS  = 16;
    localparam int SPRITE_H_SMALL = 8;
    localparam int SPRITE_H_LARGE = 16;

    localparam int OAM_IDX_W  = 6;
    localparam int SLOT_ROW_W = 4;

    typedef struct packed {
        logic [OAM_IDX_W-1:0]  idx;
        logic [7:0]            x;
        logic [SLOT_ROW_W-1:0] row;
    } slot_t;

    function automatic logic [7:0] oam_addr(input logic [OAM_IDX_W-1:0] entry, input int ofs);
        return 8'({2'b00, entry} * 8'(OAM_ENTRY_BYTES) + 8'(ofs));
    endfunction

    // Row of the sprite that lands on this line; wraps when the sprite starts below it.
    function automatic logic [8:0] sprite_offset(input logic [7:0] line, input logic [7:0] y);
        return {1'b0, line} + 9'(SPRITE_Y_BIAS) - {1'b0, y};
    endfunction

    function automatic logic sprite_visible(input logic [7:0] line, input logic [7:0] y,
                                            input logic tall);
        logic [8:0] biased;
        logic [8:0] height;
        biased = {1'b0, line} + 9'(SPRITE_Y_BIAS);
        height = tall ? 9'(SPRITE_H_LARGE) : 9'(SPRITE_H_SMALL);
        return (biased >= {1'b0, y}) && (sprite_offset(line, y) < height);
    endfunction

endpackage

// File: rtl/ppu_sprite_slot_buffer.sv
// Per-line list of sprites found by the OAM scan; one synchronous write port
// for the scanner and a combinational read port for the sprite fetcher.
module ppu_sprite_slot_buffer
    import ppu_pkg::*;
#(
    parameter int MAX_SPRITES = 10,
    parameter int SLOT_W      = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  slot_t             wr_data,
    input  logic [SLOT_W-1:0] rd_slot,
    output slot_t             rd_data
);

    // Contents are rebuilt every line, so the storage needs no reset.
    slot_t slots [MAX_SPRITES];

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_SPRITES; i++) begin
            if (wr_en && (wr_slot == SLOT_W'(i))) begin
                slots[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < MAX_SPRITES; i++) begin
            if (rd_slot == SLOT_W'(i)) begin
                rd_data = slots[i];
            end
        end
    end

endmodule

// File: rtl/ppu_oam_scan.sv
// PPU mode-2 sprite search: walks all OAM entries (Y then X byte, two clocks
// per entry) and records the first MAX_SPRITES that intersect the current line.
module ppu_oam_scan
    import ppu_pkg::*;
#(
    parameter int NUM_ENTRIES = 40,
    parameter int MAX_SPRITES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ly,
    input  logic       obj_size,
    input  logic       dma_active,
    output logic [7:0] adr_oam,
    output logic       read,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [3:0] count,
    input  logic [3:0] rd_slot,
    output logic [5:0] rd_idx,
    output logic [7:0] rd_x,
    output logic [3:0] rd_row
);

    localparam int SLOT_W = 4;

    scan_state_t          state;
    logic                 start_q;
    logic [7:0]           ly_q;
    logic                 tall_q;
    logic [OAM_IDX_W-1:0] entry;
    logic                 pending;
    logic [3:0]           row_q;
    logic                 dma_seen;

    logic                 commit;
    logic [OAM_IDX_W-1:0] commit_idx;
    logic [8:0]           y_offset;
    slot_t                wr_data;
    slot_t                rd_data;

    // An entry's X byte arrives one state after its Y check, so the slot write
    // happens in the next SCAN_Y (or in FINISH for the last entry).
    always_comb begin
        commit     = 1'b0;
        commit_idx = entry;
        if ((state == S_SCAN_Y || state == S_FINISH) && pending &&
            (count < 4'(MAX_SPRITES))) begin
            commit = 1'b1;
        end
        if (state == S_SCAN_Y) begin
            commit_idx = entry - 6'd1;
        end
        wr_data  = '{idx: commit_idx, x: din, row: row_q};
        y_offset = sprite_offset(ly_q, din);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            ly_q     <= '0;
            tall_q   <= 1'b0;
            entry    <= '0;
            count    <= '0;
            pending  <= 1'b0;
            row_q    <= '0;
            dma_seen <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            read     <= 1'b0;
            adr_oam  <= '0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            if (start) begin
                ly_q   <= ly;
                tall_q <= obj_size;
            end

            if (start_q) begin
                state    <= S_SCAN_Y;
                entry    <= '0;
                count    <= '0;
                pending  <= 1'b0;
                dma_seen <= 1'b0;
                busy     <= 1'b1;
                read     <= 1'b1;
                adr_oam  <= oam_addr('0, OAM_Y_OFS);
            end else begin
                case (state)
                    S_IDLE: begin
                        read <= 1'b0;
                    end
                    S_SCAN_Y: begin
                        if (commit) begin
                            count <= count + 4'd1;
                        end
                        dma_seen <= dma_active;
                        state    <= S_SCAN_X;
                        read     <= 1'b1;
                        adr_oam  <= oam_addr(entry, OAM_X_OFS);
                    end
                    S_SCAN_X: begin
                        // A byte read while DMA owns OAM is garbage; drop the whole entry.
                        pending <= sprite_visible(ly_q, din, tall_q) && !dma_seen && !dma_active;
                        row_q   <= y_offset[3:0];
                        if (entry == 6'(NUM_ENTRIES - 1)) begin
                            state <= S_FINISH;
                            read  <= 1'b0;
                        end else begin
                            entry   <= entry + 6'd1;
                            state   <= S_SCAN_Y;
                            read    <= 1'b1;
                            adr_oam <= oam_addr(entry + 6'd1, OAM_Y_OFS);
                        end
                    end
                    S_FINISH: begin
                        if (commit) begin
                            count <= count + 4'd1;
                        end
                        pending <= 1'b0;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    ppu_sprite_slot_buffer #(
        .MAX_SPRITES (MAX_SPRITES),
        .SLOT_W      (SLOT_W)
    ) u_slots (
        .clk     (clk),
        .wr_en   (commit),
        .wr_slot (count),
        .wr_data (wr_data),
        .rd_slot (rd_slot),
        .rd_data (rd_data)
    );

    assign rd_idx = rd_data.idx;
    assign rd_x   = rd_data.x;
    assign rd_row = rd_data.row;

endmodule

// File: tb/tb_ppu_oam_scan.sv
// Self-checking bench for ppu_oam_scan: an OAM model answers the scanner's reads
// and a reference search fills a scoreboard that is drained when done pulses.
module tb_ppu_oam_scan;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] ly = 8'd0;
    logic       obj_size = 1'b0;
    logic       dma_active = 1'b0;
    logic [7:0] adr_oam;
    logic       read;
    logic [7:0] din = 8'd0;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic [3:0] rd_slot = 4'd0;
    logic [5:0] rd_idx;
    logic [7:0] rd_x;
    logic [3:0] rd_row;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  oam [160];
    int          exp_count_q[$];
    logic [17:0] exp_slot_q[$];

    int          busy_cycles;
    int          done_at;
    int          done_count;
    int          obs_count;
    logic [17:0] obs_slot [10];

    ppu_oam_scan dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ly         (ly),
        .obj_size   (obj_size),
        .dma_active (dma_active),
        .adr_oam    (adr_oam),
        .read       (read),
        .din        (din),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .rd_slot    (rd_slot),
        .rd_idx     (rd_idx),
        .rd_x       (rd_x),
        .rd_row     (rd_row)
    );

    always #5 clk = ~clk;

    // OAM answers one cycle after the read strobe.
    always @(posedge clk) begin
        if (read) din <= oam[adr_oam];
    end

    function automatic void clear_oam();
        for (int i = 0; i < 160; i++) oam[i] = 8'h00;
    endfunction

    // Reference sprite search over the OAM image as seen at start time.
    function automatic void push_expected(int line, bit tall, int blocked);
        int n = 0;
        int t;
        int h = tall ? 16 : 8;
        for (int e = 0; e < 40; e++) begin
            t = line + 16 - int'(oam[4*e]);
            if (t >= 0 && t < h && e != blocked && n < 10) begin
                exp_slot_q.push_back({6'(e), oam[4*e+1], 4'(t)});
                n++;
            end
        end
        exp_count_q.push_back(n);
    endfunction

    task automatic run_scan(input logic [7:0] ly_v, input logic size_v,
                            input int dma_entry, input int restart_at);
        int limit;
        busy_cycles = 0;
        done_at     = -1;
        done_count  = 0;
        if (restart_at == 0) push_expected(int'(ly_v), size_v, dma_entry);
        else                 push_expected(int'(ly_v), size_v, -1);
        ly       = ly_v;
        obj_size = size_v;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        limit = restart_at + 90;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                if (done_at < 0) done_at = k;
            end
            dma_active = (dma_entry >= 0) && (k == 1 + 2*dma_entry);
            start      = (restart_at > 0) && (k == restart_at - 1);
        end
        dma_active = 1'b0;
        start      = 1'b0;
        obs_count  = int'(count);
        for (int i = 0; i < 10; i++) begin
            rd_slot = 4'(i);
            #1;
            obs_slot[i] = {rd_idx, rd_x, rd_row};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #2;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        tests_run++; if (count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        tests_run++; if (read !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_read: got %b want 0", read); end
        tests_run++; if (adr_oam !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_adr: got %0d want 0", adr_oam); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_empty();
        int exp_n;
        clear_oam();
        run_scan(8'd40, 1'b0, -1, 0);
        tests_run++; if (busy_cycles !== 81) begin tests_failed++; $display("[TB] FAIL empty_busy_len: got %0d want 81", busy_cycles); end
        tests_run++; if (done_at !== 82) begin tests_failed++; $display("[TB] FAIL empty_done_at: got %0d want 82", done_at); end
        tests_run++; if (done_count !== 1) begin tests_failed++; $display("[TB] FAIL empty_done_pulses: got %0d want 1", done_count); end
        exp_n = exp_count_q.pop_front();
        tests_run++; if (obs_count !== exp_n) begin tests_failed++; $display("[TB] FAIL empty_count: got %0d want %0d", obs_count, exp_n); end
        for (int i = 0; i < exp_n; i++) void'(exp_slot_q.pop_front());
    endtask

    task automatic test_single();
        int lys [3]  = '{40, 47, 48};
        int rows [3] = '{0, 7, -1};
        int exp_n;
        logic [17:0] exp_s;
        logic [17:0] want;
        clear_oam();
        oam[20] = 8'd56;  oam[21] = 8'd20;
        oam[40] = 8'd170; oam[41] = 8'd33;
        for (int j = 0; j < 3; j++) begin
            run_scan(8'(lys[j]), 1'b0, -1, 0);
            exp_n = exp_count_q.pop_front();
            tests_run++; if (obs_count !== exp_n) begin tests_failed++; $display("[TB] FAIL single_count ly=%0d: got %0d want %0d", lys[j], obs_count, exp_n); end
            for (int i = 0; i < exp_n; i++) begin
                exp_s = exp_slot_q.pop_front();
                tests_run++; if (obs_slot[i] !== exp_s) begin tests_failed++; $display("[TB] FAIL single_slot%0d ly=%0d: got %h want %h", i, lys[j], obs_slot[i], exp_s); end
            end
            if (rows[j] >= 0) begin
                want = {6'd5, 8'd20, 4'(rows[j])};
                tests_run++; if (obs_slot[0] !== want) begin tests_failed++; $display("[TB] FAIL single_fixed ly=%0d: got %h want %h", lys[j], obs_slot[0], want); end
            end else begin
                tests_run++; if (obs_count !== 0) begin tests_failed++; $display("[TB] FAIL single_fixed ly=%0d: got count %0d want 0", lys[j], obs_count); end
            end
        end
    endtask

    task automatic test_tall();
        int exp_n;
        logic [17:0] exp_s;
        clear_oam();
        oam[12] = 8'd50; oam[13] = 8'd99;
        for (int s = 1; s >= 0; s--) begin
            run_scan(8'd49, 1'(s), -1, 0);
            exp_n = exp_count_q.pop_front();
            tests_run++; if (obs_count !== exp_n) begin tests_failed++; $display("[TB] FAIL tall_count size=%0d: got %0d want %0d", s, obs_count, exp_n); end
            for (int i = 0; i < exp_n; i++) begin
                exp_s = exp_slot_q.pop_front();
                tests_run++; if (obs_slot[i] !== exp_s) begin tests_failed++; $display("[TB] FAIL tall_slot%0d: got %h want %h", i, obs_slot[i], exp_s); end
            end
        end
        tests_run++; if (obs_count !== 0) begin tests_failed++; $display("[TB] FAIL tall_short_invisible: got %0d want 0", obs_count); end
    endtask

    task automatic test_limit();
        int exp_n;
        logic [17:0] exp_s;
        clear_oam();
        for (int e = 0; e < 15; e++) begin
            oam[4*e]   = 8'd16;
            oam[4*e+1] = (e == 0) ? 8'd0 : (e == 1) ? 8'd200 : 8'(e * 10);
        end
        run_scan(8'd0, 1'b0, -1, 0);
        exp_n = exp_count_q.pop_front();
        tests_run++; if (obs_count !== exp_n) begin tests_failed++; $display("[TB] FAIL limit_count: got %0d want %0d", obs_count, exp_n); end
        tests_run++; if (count !== 4'd10) begin tests_failed++; $display("[TB] FAIL limit_saturate: got %0d want 10", count); end
        for (int i = 0; i < exp_n; i++) begin
            exp_s = exp_slot_q.pop_front();
            tests_run++; if (obs_slot[i] !== exp_s) begin tests_failed++; $display("[TB] FAIL limit_slot%0d: got %h want %h", i, obs_slot[i], exp_s); end
        end
    endtask

    task automatic test_dma();
        int exp_n;
        logic [17:0] exp_s;
        clear_oam();
        oam[20] = 8'd16; oam[21] = 8'd5;
        oam[28] = 8'd16; oam[29] = 8'd7;
        oam[36] = 8'd16; oam[37] = 8'd9;
        run_scan(8'd0, 1'b0, 7, 0);
        exp_n = exp_count_q.pop_front();
        tests_run++; if (obs_count !== exp_n) begin tests_failed++; $display("[TB] FAIL dma_count: got %0d want %0d", obs_count, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            exp_s = exp_slot_q.pop_front();
            tests_run++; if (obs_slot[i] !== exp_s) begin tests_failed++; $display("[TB] FAIL dma_slot%0d: got %h want %h", i, obs_slot[i], exp_s); end
        end
    endtask

    task automatic test_back_to_back();
        int exp_n;
        logic [17:0] exp_s;
        run_scan(8'd0, 1'b0, 7, 40);
        tests_run++; if (done_count !== 1) begin tests_failed++; $display("[TB] FAIL restart_done_pulses: got %0d want 1", done_count); end
        tests_run++; if (done_at !== 122) begin tests_failed++; $display("[TB] FAIL restart_done_at: got %0d want 122", done_at); end
        tests_run++; if (busy_cycles !== 121) begin tests_failed++; $display("[TB] FAIL restart_busy_len: got %0d want 121", busy_cycles); end
        exp_n = exp_count_q.pop_front();
        tests_run++; if (obs_count !== exp_n) begin tests_failed++; $display("[TB] FAIL restart_count: got %0d want %0d", obs_count, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            exp_s = exp_slot_q.pop_front();
            tests_run++; if (obs_slot[i] !== exp_s) begin tests_failed++; $display("[TB] FAIL restart_slot%0d: got %h want %h", i, obs_slot[i], exp_s); end
        end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        int exp_n;
        logic [17:0] exp_s;
        clear_oam();
        for (int e = 0; e < 15; e++) begin
            oam[4*e]   = 8'd16;
            oam[4*e+1] = 8'(e + 1);
        end
        ly = 8'd0; obj_size = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_done: got %b want 0", done); end
        tests_run++; if (count !== 4'd0) begin tests_failed++; $display("[TB] FAIL midreset_count: got %0d want 0", count); end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        tests_run++; if (stray !== 0) begin tests_failed++; $display("[TB] FAIL midreset_stray_done: got %0d want 0", stray); end
        run_scan(8'd0, 1'b0, -1, 0);
        tests_run++; if (done_at !== 82) begin tests_failed++; $display("[TB] FAIL postreset_done_at: got %0d want 82", done_at); end
        exp_n = exp_count_q.pop_front();
        tests_run++; if (obs_count !== exp_n) begin tests_failed++; $display("[TB] FAIL postreset_count: got %0d want %0d", obs_count, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            exp_s = exp_slot_q.pop_front();
            tests_run++; if (obs_slot[i] !== exp_s) begin tests_failed++; $display("[TB] FAIL postreset_slot%0d: got %h want %h", i, obs_slot[i], exp_s); end
        end
    endtask

    initial begin
        clear_oam();
        test_reset();
        test_empty();
        test_single();
        test_tall();
        test_limit();
        test_dma();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
